dmem_bytelane: RTL and testbench
================================

// Module: dmem_bytelane
// PURPOSE
//  Parametrised data memory for the RV32 pipeline MEM stage.
//  Replaces the flat word-array DMEM: byte-addressed, with RV32 LB/LH/LW/LBU/LHU/SB/SH/SW lane handling.
//  Single-outstanding valid/ready request port, programmable wait states, registered response.
//  Reports misaligned, out-of-range and illegal-size accesses on rsp_err.
// PARAMETERS
//  DEPTH        256  number of 32-bit words (power of 2, >=4)
//  AW           32   byte-address width (must be >= log2(DEPTH)+2)
//  WAIT_STATES  0    extra cycles between accept and response (0..15)
// PORTS
//  clk           in   1   rising-edge clock
//  rst_n         in   1   asynchronous active-low reset
//  req_valid     in   1   request present
//  req_ready     out  1   block can accept; transfer when req_valid & req_ready
//  req_we        in   1   1 = store, 0 = load
//  req_size      in   2   00 byte, 01 half, 10 word, 11 illegal
//  req_unsigned  in   1   load zero-extend (LBU/LHU); ignored for word and stores
//  req_addr      in   AW  byte address
//  req_wdata     in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//  rsp_valid     out  1   one-cycle pulse, response valid
//  rsp_rdata     out  32  load data, extended; 0 for stores and errors
//  rsp_err       out  1   access faulted (qualified by rsp_valid)
// BEHAVIOUR
//  Reset (async, rst_n=0): FSM->IDLE, wait counter=0, req_ready=0 while in reset, rsp_valid=0,
//   rsp_rdata=0, rsp_err=0, captured request regs=0. Memory array contents NOT reset.
//  FSM: IDLE -(accept, WAIT_STATES>0)-> WAIT -(count==WAIT_STATES-1)-> RESP -> IDLE.
//   IDLE -(accept, WAIT_STATES==0)-> RESP. req_ready=1 only in IDLE (see CONFIGURATION).
//  Request fields captured on accept; inputs ignored until next accept.
//  Latency: rsp_valid asserts exactly WAIT_STATES+1 cycles after the accept edge, for one cycle.
//  Error = size==11 | (half & addr[0]) | (word & addr[1:0]!=0) | (addr>>2 >= DEPTH).
//   On error: no memory write, rsp_rdata=0, rsp_err=1.
//  Store: committed on the clock edge that enters RESP; byte-enable from size/addr[1:0]:
//   SB -> lane addr[1:0]; SH -> lanes {addr[1],0}..+1; SW -> all four. Other lanes unchanged.
//  Load: word read at the same edge; lane selected by addr[1:0]; sign-extend unless req_unsigned.
//  Word index = addr[log2(DEPTH)+1:2]; upper address bits only checked for range.
//  Reset asserted mid-operation: pending access dropped, store not committed if RESP not yet entered.
//  req_valid deasserted without accept: no effect; no requirement that valid be held.
// CONFIGURATION
//  DMEM_B2B_EN defined: req_ready=1 in RESP as well as IDLE; an accept in RESP proceeds as from
//   IDLE (throughput 1 access/cycle when WAIT_STATES==0, load after store to same address
//   returns the new data since the store committed on the preceding edge).
//  Not defined: req_ready=1 only in IDLE; max throughput 1 access per WAIT_STATES+2 cycles.
// STRUCTURE
//  Shared package dmem_pkg: size enum (SZ_B, SZ_H, SZ_W, SZ_ILL), FSM state enum (S_IDLE,
//   S_WAIT, S_RESP), function for byte-enable generation, function for load extract/extend.
//  One sub-module dmem_lane_align (combinational): size/addr/wdata -> byte-enable + lane-shifted
//   wdata, and raw word -> extended rdata. Array and FSM stay in dmem_bytelane.
// TESTING
//  1. SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rsp_rdata 0xDEADBEEF, rsp_err 0.
//  2. SB 0x13 data 0x80 over 0x11223344; LB 0x13 -> 0xFFFFFF80, LBU 0x13 -> 0x00000080, LW -> 0x80223344.
//  3. SH 0x21 data 0xABCD -> rsp_err 1, LW 0x20 unchanged; LW 0x4*DEPTH -> rsp_err 1, rdata 0.
//  4. WAIT_STATES=3: accept at cycle n -> rsp_valid only at n+4; req_ready 0 for cycles n+1..n+4.
//  5. Reset pulse during WAIT after SW 0x30 0x12345678 -> rsp_valid never asserts, LW 0x30 shows old data.
//  6. DMEM_B2B_EN, WAIT_STATES=0: SW 0x40 0xCAFEF00D then LW 0x40 on next cycle -> 0xCAFEF00D, one rsp per cycle.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the byte-lane data memory.
//   size_e  : access size encoding on req_size (SZ_B, SZ_H, SZ_W, SZ_ILL)
//   state_e : request FSM states (S_IDLE, S_WAIT, S_RESP)
//   byte_en      : size + byte offset -> 4-bit lane enable
//   load_extract : raw 32-bit word -> selected lane, sign/zero extended
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_ILL = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_RESP = 2'b10
    } state_e;

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] offset);
        logic [3:0] be;
        case (size)
            SZ_B:    be = 4'b0001 << offset;
            SZ_H:    be = offset[1] ? 4'b1100 : 4'b0011;
            SZ_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] offset, input logic uns);
        logic [31:0] shifted;
        logic [31:0] result;
        // Bring the addressed lane down to bit 0; halves are aligned so offset is 0 or 2.
        shifted = word >> {offset, 3'b000};
        case (size)
            SZ_B:    result = uns ? {24'b0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
            SZ_H:    result = uns ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            SZ_W:    result = word;
            default: result = 32'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational lane steering between the bus and the word array.
// Ports:
//   size    in  2   access size (size_e encoding)
//   offset  in  2   byte address bits [1:0]
//   uns     in  1   zero-extend loads
//   wdata   in  32  right-aligned store data
//   rword   in  32  raw word read from the array
//   be      out 4   byte-lane write enable
//   wlane   out 32  store data replicated into every lane (be picks the live ones)
//   rdata   out 32  extracted and extended load data
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        uns,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wlane,
    output logic [31:0] rdata
);

    assign be    = byte_en(size, offset);
    assign rdata = load_extract(rword, size, offset, uns);

    always_comb begin
        wlane = wdata;
        case (size)
            SZ_B:    wlane = {4{wdata[7:0]}};
            SZ_H:    wlane = {2{wdata[15:0]}};
            default: wlane = wdata;
        endcase
    end

endmodule

// File: rtl/dmem_bytelane.sv
// dmem_bytelane: byte-addressed RV32 data memory with valid/ready request port,
// programmable wait states and a registered one-cycle response.
// Optional build macro: DMEM_B2B_EN -- also accept a new request while in RESP.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_valid/req_ready        request handshake
//   req_we, req_size,
//   req_unsigned, req_addr,
//   req_wdata                  request fields, captured on accept
//   rsp_valid                  one-cycle response pulse
//   rsp_rdata                  extended load data (0 for stores and errors)
//   rsp_err                    misaligned / out-of-range / illegal size
//
// state  | meaning
// S_IDLE | ready for a request
// S_WAIT | counting down programmed wait states
// S_RESP | response presented; access committed on the edge that entered it
module dmem_bytelane
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int AW          = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          rsp_valid,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err
);

    localparam int         IW        = $clog2(DEPTH);
    localparam bit         ZERO_WAIT = (WAIT_STATES == 0);
    localparam logic [3:0] CNT_LOAD  = ZERO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

    state_e        state;
    logic [3:0]    cnt;
    logic          cap_we;
    logic [1:0]    cap_size;
    logic          cap_uns;
    logic [AW-1:0] cap_addr;
    logic [31:0]   cap_wdata;

    logic [31:0]   mem [DEPTH];

    logic          accept;
    logic          enter_resp;
    logic          acc_we;
    logic [1:0]    acc_size;
    logic          acc_uns;
    logic [AW-1:0] acc_addr;
    logic [31:0]   acc_wdata;
    logic          err;
    logic [IW-1:0] idx;
    logic [31:0]   rword;
    logic [3:0]    be;
    logic [31:0]   wlane;
    logic [31:0]   rdata_ext;

    // Ready is gated by rst_n so nothing is accepted while reset is held.
`ifdef DMEM_B2B_EN
    assign req_ready = rst_n & ((state == S_IDLE) | (state == S_RESP));
`else
    assign req_ready = rst_n & (state == S_IDLE);
`endif

    assign accept = req_valid & req_ready;

    // With no wait states the access completes on the accept edge itself, so it
    // must use the live request fields; otherwise the captured copy is used.
    assign enter_resp = ZERO_WAIT ? accept : ((state == S_WAIT) && (cnt == 4'd0));
    assign acc_we     = ZERO_WAIT ? req_we       : cap_we;
    assign acc_size   = ZERO_WAIT ? req_size     : cap_size;
    assign acc_uns    = ZERO_WAIT ? req_unsigned : cap_uns;
    assign acc_addr   = ZERO_WAIT ? req_addr     : cap_addr;
    assign acc_wdata  = ZERO_WAIT ? req_wdata    : cap_wdata;

    assign err = (acc_size == SZ_ILL)
               | ((acc_size == SZ_H) & acc_addr[0])
               | ((acc_size == SZ_W) & (|acc_addr[1:0]))
               | ((acc_addr >> 2) >= AW'(DEPTH));

    assign idx   = acc_addr[IW+1:2];
    assign rword = mem[idx];

    dmem_lane_align u_align (
        .size   (acc_size),
        .offset (acc_addr[1:0]),
        .uns    (acc_uns),
        .wdata  (acc_wdata),
        .rword  (rword),
        .be     (be),
        .wlane  (wlane),
        .rdata  (rdata_ext)
    );

    // Array is not reset; stores land on the edge that enters RESP.
    always_ff @(posedge clk) begin
        if (enter_resp && acc_we && !err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            cap_we    <= 1'b0;
            cap_size  <= 2'b00;
            cap_uns   <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= 32'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'b0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= enter_resp;
            rsp_err   <= enter_resp & err;
            rsp_rdata <= (enter_resp && !acc_we && !err) ? rdata_ext : 32'b0;

            if (accept) begin
                cap_we    <= req_we;
                cap_size  <= req_size;
                cap_uns   <= req_unsigned;
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
            end

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state <= ZERO_WAIT ? S_RESP : S_WAIT;
                        cnt   <= CNT_LOAD;
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) state <= S_RESP;
                    else             cnt   <= cnt - 4'd1;
                end
                S_RESP: begin
                    if (accept) begin
                        state <= ZERO_WAIT ? S_RESP : S_WAIT;
                        cnt   <= CNT_LOAD;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bytelane.sv
// Bench for dmem_bytelane: one instance with no wait states, one with three.
// Expected responses are queued with their due cycle when a request is accepted
// and compared when that cycle arrives; every other cycle must show no response.
module tb_dmem_bytelane;

    localparam int DEPTH = 64;
    localparam int AW    = 32;

    typedef struct {
        int          due;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    bit   mon_on;
    int   n_checks;
    int   n_fail;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    logic        v0, rdy0, we0, uns0, rv0, re0;
    logic [1:0]  sz0;
    logic [31:0] a0, wd0, rd0;
    logic        v1, rdy1, we1, uns1, rv1, re1;
    logic [1:0]  sz1;
    logic [31:0] a1, wd1, rd1;

    dmem_bytelane #(.DEPTH(DEPTH), .AW(AW), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(v0), .req_ready(rdy0), .req_we(we0), .req_size(sz0),
        .req_unsigned(uns0), .req_addr(a0), .req_wdata(wd0),
        .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(re0)
    );

    dmem_bytelane #(.DEPTH(DEPTH), .AW(AW), .WAIT_STATES(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(v1), .req_ready(rdy1), .req_we(we1), .req_size(sz1),
        .req_unsigned(uns1), .req_addr(a1), .req_wdata(wd1),
        .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(re1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (q0.size() > 0 && q0[0].due == cyc) begin
                e0 = q0.pop_front();
                check_val("rsp0_valid", rv0, 1);
                check_val("rsp0_rdata", rd0, e0.rdata);
                check_val("rsp0_err",   re0, e0.err);
            end else begin
                check_val("rsp0_quiet", rv0, 0);
            end
        end
    end

    always @(negedge clk) begin
        if (mon_on) begin
            if (q1.size() > 0 && q1[0].due == cyc) begin
                e1 = q1.pop_front();
                check_val("rsp1_valid", rv1, 1);
                check_val("rsp1_rdata", rd1, e1.rdata);
                check_val("rsp1_err",   re1, e1.err);
            end else begin
                check_val("rsp1_quiet", rv1, 0);
            end
        end
    end

    // Drives one request on instance sel, waits (bounded) for the accept, and
    // queues the expected response when track is set. Returns the accept cycle.
    task automatic do_req(input int sel, input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, input logic exp_err, input bit track,
                          output int acc_cyc);
        exp_t e;
        bit   got;
        got = 1'b0;
        acc_cyc = -1;
        if (sel == 0) begin
            v0 = 1'b1; we0 = we; sz0 = size; uns0 = uns; a0 = addr; wd0 = wdata;
        end else begin
            v1 = 1'b1; we1 = we; sz1 = size; uns1 = uns; a1 = addr; wd1 = wdata;
        end
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if ((sel == 0) ? rdy0 : rdy1) got = 1'b1;
        end
        check_val("ready_wait", got, 1);
        if (got) begin
            acc_cyc = cyc;
            e.due   = cyc + ((sel == 0) ? 0 : 3) + 1;
            e.rdata = exp_rd;
            e.err   = exp_err;
            if (track) begin
                if (sel == 0) q0.push_back(e);
                else          q1.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        if (sel == 0) v0 = 1'b0;
        else          v1 = 1'b0;
    endtask

    task automatic st0(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic exp_err);
        int c;
        do_req(0, 1'b1, size, 1'b0, addr, wdata, 32'h0, exp_err, 1'b1, c);
    endtask

    task automatic ld0(input logic [1:0] size, input logic uns, input logic [31:0] addr,
                       input logic [31:0] exp_rd, input logic exp_err);
        int c;
        do_req(0, 1'b0, size, uns, addr, 32'h0, exp_rd, exp_err, 1'b1, c);
    endtask

    initial begin
        int acc_a, acc_b, acc_n;
        n_checks = 0;
        n_fail   = 0;
        mon_on   = 1'b0;
        rst_n    = 1'b0;
        v0 = 0; we0 = 0; sz0 = 0; uns0 = 0; a0 = 0; wd0 = 0;
        v1 = 0; we1 = 0; sz1 = 0; uns1 = 0; a1 = 0; wd1 = 0;

        repeat (3) @(negedge clk);
        check_val("rst_ready0", rdy0, 0);
        check_val("rst_ready1", rdy1, 0);
        check_val("rst_valid0", rv0, 0);
        check_val("rst_rdata0", rd0, 0);
        check_val("rst_err0",   re0, 0);
        check_val("rst_valid1", rv1, 0);
        rst_n  = 1'b1;
        mon_on = 1'b1;
        @(negedge clk);
        check_val("idle_ready0", rdy0, 1);
        check_val("idle_ready1", rdy1, 1);
        @(posedge clk);
        #1;

        // word store / load
        st0(2'b10, 32'h10, 32'hDEADBEEF, 1'b0);
        ld0(2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);

        // byte store into a known word, then byte/half/word loads
        st0(2'b10, 32'h10, 32'h11223344, 1'b0);
        st0(2'b00, 32'h13, 32'h00000080, 1'b0);
        ld0(2'b00, 1'b0, 32'h13, 32'hFFFFFF80, 1'b0);
        ld0(2'b00, 1'b1, 32'h13, 32'h00000080, 1'b0);
        ld0(2'b10, 1'b0, 32'h10, 32'h80223344, 1'b0);
        ld0(2'b01, 1'b0, 32'h12, 32'hFFFF8022, 1'b0);
        ld0(2'b01, 1'b1, 32'h12, 32'h00008022, 1'b0);
        ld0(2'b00, 1'b0, 32'h10, 32'h00000044, 1'b0);
        ld0(2'b00, 1'b0, 32'h11, 32'h00000033, 1'b0);

        // faults leave memory untouched
        st0(2'b10, 32'h20, 32'h55667788, 1'b0);
        st0(2'b01, 32'h21, 32'h0000ABCD, 1'b1);
        ld0(2'b10, 1'b0, 32'h20, 32'h55667788, 1'b0);
        ld0(2'b10, 1'b0, 32'h4 * DEPTH, 32'h0, 1'b1);
        st0(2'b10, 32'h4 * DEPTH + 32'h20, 32'hFFFFFFFF, 1'b1);
        ld0(2'b10, 1'b0, 32'h22, 32'h0, 1'b1);
        ld0(2'b11, 1'b0, 32'h20, 32'h0, 1'b1);
        ld0(2'b01, 1'b1, 32'h23, 32'h0, 1'b1);
        ld0(2'b10, 1'b0, 32'h20, 32'h55667788, 1'b0);
        // valid upper-half store
        st0(2'b01, 32'h22, 32'h0000BEEF, 1'b0);
        ld0(2'b10, 1'b0, 32'h20, 32'hBEEF7788, 1'b0);
        ld0(2'b01, 1'b0, 32'h20, 32'h00007788, 1'b0);

        // back-to-back store then load on the same word
        do_req(0, 1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D, 32'h0, 1'b0, 1'b1, acc_a);
        do_req(0, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1, acc_b);
`ifdef DMEM_B2B_EN
        check_val("b2b_gap", acc_b - acc_a, 1);
`else
        check_val("seq_gap", acc_b - acc_a, 2);
`endif

        // three wait states: latency and ready profile, inputs scrambled after accept
        do_req(1, 1'b1, 2'b10, 1'b0, 32'h30, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b1, acc_n);
        do_req(1, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b1, acc_n);
        we1 = 1'b1; sz1 = 2'b11; a1 = 32'hFFFFFFFF; wd1 = 32'h0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check_val("ws_cycle", cyc - acc_n, i);
`ifdef DMEM_B2B_EN
            check_val("ws_ready", rdy1, (i == 4) ? 1 : 0);
`else
            check_val("ws_ready", rdy1, 0);
`endif
        end
        @(negedge clk);
        check_val("ws_ready_back", rdy1, 1);
        @(posedge clk);
        #1;

        // reset during WAIT drops the store and its response
        do_req(1, 1'b1, 2'b10, 1'b0, 32'h30, 32'h12345678, 32'h0, 1'b0, 1'b0, acc_n);
        rst_n = 1'b0;
        @(negedge clk);
        check_val("midrst_ready", rdy1, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;
        do_req(1, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b1, acc_n);
        do_req(1, 1'b0, 2'b00, 1'b0, 32'h31, 32'h0, 32'hFFFFFFA5, 1'b0, 1'b1, acc_n);

        repeat (8) @(negedge clk);
        check_val("q0_drained", q0.size(), 0);
        check_val("q1_drained", q1.size(), 0);
        mon_on = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
